// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states, flag bundle
// and the width of the iteration counter.
package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_SHL    = 3'b100;
    localparam logic [2:0] OP_SHR    = 3'b101;
    localparam logic [2:0] OP_CONCAT = 3'b110;
    localparam logic [2:0] OP_MUL    = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

    // One extra bit so the counter can hold WIDTH itself (mul iteration count).
    function automatic int shcnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle ALU ops (add, sub, and, or, concat) with carry/overflow.
// Op 111 evaluates as add; the top only uses it when the multiplier is not built.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IMM_BITS = 9
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] imm_mask;

    assign sum      = {1'b0, x} + {1'b0, y};
    // Top bit of the widened difference is the unsigned borrow (x < y).
    assign diff     = {1'b0, x} - {1'b0, y};
    assign imm_mask = {{(WIDTH-IMM_BITS){1'b0}}, {IMM_BITS{1'b1}}};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:    result = x & y;
            OP_OR:     result = x | y;
            OP_CONCAT: result = (x << IMM_BITS) | (y & imm_mask);
            OP_SHL, OP_SHR: result = '0;
            default: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle ops, bit-serial shifts
// and, when ALU_MUL_EN is defined, a shift-add multiplier sharing one output register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IMM_BITS = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    localparam int               CW      = shcnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_MUL = CW'(WIDTH);
    localparam logic [WIDTH-1:0] SAT_Y   = WIDTH'(WIDTH - 1);

    alu_state_e       state, next_state, launch_state;
    logic             accept, is_shift, is_mul, sat;
    logic [CW-1:0]    cnt, s_init;
    logic [WIDTH-1:0] sh_val, sh_next;
    logic             sh_left, sh_out;
    logic [WIDTH-1:0] core_res;
    logic             core_carry, core_ovf;
    logic             load_res, carry_d, ovf_d;
    logic [WIDTH-1:0] res_d, result_q;
    alu_flags_t       flags_q;

    alu_seq_core #(
        .WIDTH    (WIDTH),
        .IMM_BITS (IMM_BITS)
    ) u_core (
        .op       (op),
        .x        (x),
        .y        (y),
        .result   (core_res),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

    assign in_ready  = !reset && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign is_shift = (op == OP_SHL) || (op == OP_SHR);
    // y >= WIDTH-1 means s = y+1 >= WIDTH: everything is shifted out.
    assign sat      = (y >= SAT_Y);
    assign s_init   = y[CW-1:0] + CNT_ONE;

    assign sh_next = sh_left ? {sh_val[WIDTH-2:0], 1'b0} : {1'b0, sh_val[WIDTH-1:1]};
    assign sh_out  = sh_left ? sh_val[WIDTH-1] : sh_val[0];

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     part;

    // Low half holds the remaining multiplier bits; add into the high half, shift right.
    assign is_mul   = (op == OP_MUL);
    assign part     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mcand};
    assign acc_next = {part, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            mcand <= '0;
        end else if (accept && is_mul) begin
            acc   <= {{WIDTH{1'b0}}, y};
            mcand <= x;
        end else if (state == MUL) begin
            acc   <= acc_next;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        launch_state = DONE;
        if (is_shift && !sat) begin
            launch_state = SHIFT;
        end else if (is_mul) begin
            launch_state = MUL;
        end
        next_state = state;
        case (state)
            IDLE:       if (accept) next_state = launch_state;
            SHIFT, MUL: if (cnt == CNT_ONE) next_state = DONE;
            DONE:       if (out_ready) next_state = accept ? launch_state : IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        load_res = 1'b0;
        res_d    = core_res;
        carry_d  = core_carry;
        ovf_d    = core_ovf;
        if (accept) begin
            if (is_shift) begin
                if (sat) begin
                    load_res = 1'b1;
                    res_d    = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                end
            end else if (!is_mul) begin
                load_res = 1'b1;
            end
        end else if (state == SHIFT && cnt == CNT_ONE) begin
            load_res = 1'b1;
            res_d    = sh_next;
            carry_d  = sh_out;
            ovf_d    = 1'b0;
        end
`ifdef ALU_MUL_EN
        else if (state == MUL && cnt == CNT_ONE) begin
            load_res = 1'b1;
            res_d    = acc_next[WIDTH-1:0];
            carry_d  = |acc_next[2*WIDTH-1:WIDTH];
            ovf_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            sh_val  <= '0;
            sh_left <= 1'b0;
        end else if (accept) begin
            cnt     <= is_mul ? CNT_MUL : s_init;
            sh_val  <= x;
            sh_left <= (op == OP_SHL);
        end else if (state == SHIFT || state == MUL) begin
            cnt     <= cnt - CNT_ONE;
            sh_val  <= sh_next;
        end
    end

    // Output register only moves on a load, so it holds steady under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (load_res) begin
            result_q          <= res_d;
            flags_q.carry     <= carry_d;
            flags_q.zero      <= (res_d == '0);
            flags_q.negative  <= res_d[WIDTH-1];
            flags_q.overflow  <= ovf_d;
        end
    end

    assign result   = result_q;
    assign carry    = flags_q.carry;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops on handshake.
// Follows ALU_MUL_EN the same way as the design build.
module tb_alu_seq;

    localparam int W   = 16;
    localparam int IMM = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, zero, negative, overflow, busy;

    alu_seq #(.WIDTH(W), .IMM_BITS(IMM)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         c, z, n, v;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_cmp = 0;
    int   rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready

    // Reference: plain arithmetic on the operation definitions, plus the latency rule.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int acc_cyc);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint hi = (longint'(1) << (W - 1)) - 1;
        longint lo = -(hi + 1);
        longint p = 0;
        longint t;
        int     s;
        int     lat = 1;
        e.c = 1'b0;
        e.v = 1'b0;
        case (o)
            3'd1: begin
                p = ua - ub;
                e.c = (ua < ub);
                t = sa - sbv;
                e.v = (t > hi) || (t < lo);
            end
            3'd2: p = ua & ub;
            3'd3: p = ua | ub;
            3'd4, 3'd5: begin
                s = int'(b) + 1;
                if (s >= W) begin
                    p = 0;
                end else begin
                    lat = 1 + s;
                    if (o == 3'd4) begin
                        p = ua << s;
                        e.c = ((ua >> (W - s)) & 1) != 0;
                    end else begin
                        p = ua >> s;
                        e.c = ((ua >> (s - 1)) & 1) != 0;
                    end
                end
            end
            3'd6: p = (ua << IMM) | (ub & ((longint'(1) << IMM) - 1));
`ifdef ALU_MUL_EN
            3'd7: begin
                p = ua * ub;
                e.c = (p >> W) != 0;
                lat = 1 + W;
            end
`endif
            default: begin
                p = ua + ub;
                e.c = ((p >> W) & 1) != 0;
                t = sa + sbv;
                e.v = (t > hi) || (t < lo);
            end
        endcase
        e.r = p[W-1:0];
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        e.cyc = acc_cyc + lat;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
            n_bad++;
        end
    endtask

    initial begin : monitor
        bit   fresh = 1'b1;
        int   first_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            #2;
            if (!out_valid) begin
                fresh = 1'b1;
            end else begin
                if (fresh) begin
                    first_cyc = cyc;
                    fresh = 1'b0;
                end
                if (sb.size() == 0) begin
                    $display("FAIL unexpected output: result %0h with no pending operation", result);
                    n_bad++;
                end else begin
                    e = sb[0];
                    chk("result",   result,    e.r);
                    chk("carry",    carry,     e.c);
                    chk("zero",     zero,      e.z);
                    chk("negative", negative,  e.n);
                    chk("overflow", overflow,  e.v);
                    chk("latency",  first_cyc, e.cyc);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_vec++;
                        fresh = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int acc_cyc);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        x = a;
        y = b;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        acc_cyc = cyc;
        if (!in_ready) begin
            $display("FAIL accept timeout: in_ready %0b, expected 1", in_ready);
            n_bad++;
        end else begin
            sb.push_back(model(o, a, b, cyc));
        end
        @(posedge clk);
        #1;
        // Scramble the operand bus so a design that failed to latch shows up.
        in_valid = 1'b0;
        op = 3'($urandom);
        x = W'($urandom);
        y = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            n_bad++;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(16'h8000);
            3:       return W'(16'h7FFF);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk_reset_state();
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst busy",      busy,      1'b0);
        chk("rst in_ready",  in_ready,  1'b0);
        chk("rst result",    result,    '0);
        chk("rst flags",     {carry, zero, negative, overflow}, 4'b0000);
    endtask

    initial begin : driver
        int           ac, t0;
        logic [2:0]   o;
        logic [W-1:0] a, b;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_state();
        @(negedge clk);
        reset = 1'b0;

        issue(3'd0, 16'hFFFF, 16'h0001, ac);
        issue(3'd1, 16'h0003, 16'h0005, ac);
        issue(3'd1, 16'h8000, 16'h0001, ac);
        issue(3'd4, 16'h0001, 16'd3,    ac);
        issue(3'd5, 16'h8001, 16'd15,   ac);
        issue(3'd5, 16'h8001, 16'd14,   ac);
        issue(3'd6, 16'h0003, 16'hFFFF, ac);
        issue(3'd7, 16'h0100, 16'h0100, ac);
        issue(3'd7, 16'h1234, 16'h0005, ac);
        drain();

        // Back-pressure: result held three cycles, then release with a same-cycle accept.
        rdy_mode = 2;
        issue(3'd0, 16'h1234, 16'h1111, ac);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp in_ready",  in_ready,  1'b0);
            chk("bp out_valid", out_valid, 1'b1);
        end
        rdy_mode = 1;
        t0 = cyc + 1;
        issue(3'd0, 16'h0001, 16'h0001, ac);
        chk("bp same-cycle accept", ac, t0);
        issue(3'd2, 16'hF0F0, 16'h3C3C, ac);
        issue(3'd3, 16'hF0F0, 16'h0F0F, ac);
        drain();
        rdy_mode = 0;

        // Reset in the middle of an iterative operation.
`ifdef ALU_MUL_EN
        issue(3'd7, 16'h0101, 16'h0101, ac);
`else
        issue(3'd4, 16'h00FF, 16'd10, ac);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_state();
        sb.delete();
        reset = 1'b0;
        issue(3'd0, 16'h0007, 16'h0009, ac);
        drain();

        for (int i = 0; i < 300; i++) begin
            o = 3'($urandom);
            a = pick();
            b = (o == 3'd4 || o == 3'd5) ? W'($urandom_range(0, 20)) : pick();
            issue(o, a, b, ac);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the 16-bit combinational ALU. It executes one operation at a time behind valid/ready handshakes on both input and output. Single-cycle ops, iterative one-bit-per-cycle shifts, and an optional shift-add multiplier all share one output register that also carries a full flag set. It sits between the decode/operand stage and writeback, and back-pressures decode while busy.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 4).
- IMM_BITS, 9, immediate field width for the concat op (1 ≤ IMM_BITS < WIDTH).
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation and operands are presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  3  operation select.
- x, y  input  WIDTH  operands.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- carry, zero, negative, overflow  output  1 each  registered flags.
- busy  output  1  state is not IDLE.

## Operation
- Ops:
  - 000 add: x+y.
  - 001 sub: x−y.
  - 010 and.
  - 011 or.
  - 100 shl: x << (y+1).
  - 101 shr: x >> (y+1), logical.
  - 110 concat: (x << IMM_BITS) | (y & (2^IMM_BITS−1)), truncated to WIDTH.
  - 111 mul (see Configuration).
- Accept occurs on in_valid && in_ready. At accept, op, x and y are latched; later input changes are ignored.
- States:
  - IDLE → DONE on accept of a single-cycle op, or of a shift whose s ≥ WIDTH.
  - IDLE → SHIFT on a shift with s < WIDTH.
  - IDLE → MUL on mul.
  - SHIFT → DONE after s iterations.
  - MUL → DONE after WIDTH iterations.
  - DONE → IDLE on out_ready with no new accept.
  - DONE → next state directly on out_ready with a simultaneous accept.
- Shift amount: s = y + 1, computed at width clog2(WIDTH)+1 with saturation. Any y ≥ WIDTH−1 gives s ≥ WIDTH, which yields result 0 and carry 0.
- in_ready = !reset && (state==IDLE || (state==DONE && out_ready)).
- out_valid = (state==DONE).
- Flag rules:
  - add: carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = signed overflow.
  - sub: carry = borrow (x < y unsigned); overflow = signed overflow.
  - and, or, concat: carry = 0, overflow = 0.
  - shifts: carry = last bit shifted out; overflow = 0.
  - mul: carry = 1 if the upper WIDTH bits of the product are nonzero; overflow = 0.
  - zero = (result==0) and negative = result[WIDTH−1], for every op.
- result and flags remain stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, result 0, all flags 0, out_valid 0, busy 0, in_ready 0 while reset is high.
- Reset mid-operation aborts the operation; no output is produced.
- Latency, for an accept in cycle N:
  - single-cycle op or saturated shift: out_valid in cycle N+1.
  - shift with s < WIDTH: out_valid in cycle N+1+s.
  - mul: out_valid in cycle N+1+WIDTH.
- Back-to-back operation is possible: when DONE, out_ready and in_valid coincide, the new op is accepted that cycle. A following single-cycle op produces out_valid again in the next cycle, giving throughput of 1 per cycle for single-cycle ops.
- Iterative ops move one operand bit per cycle using a down-counter of clog2(WIDTH)+1 bits. The block leaves SHIFT/MUL when the counter reaches 1.

## Configuration
- ALU_MUL_EN defined:
  - op 111 runs an unsigned shift-add multiply over WIDTH cycles in MUL state, using a 2·WIDTH-bit accumulator.
  - result is the low WIDTH bits of the product.
- ALU_MUL_EN undefined:
  - MUL state and accumulator are absent.
  - op 111 behaves exactly as add (single-cycle, same flags).

## Structure
- Package alu_pkg holds:
  - the op encoding constants (OP_ADD … OP_MUL);
  - the state enum (IDLE, SHIFT, MUL, DONE);
  - a shift-count width function clog2(WIDTH)+1.
- Sub-module alu_seq_core: purely combinational single-cycle ops (add, sub, and, or, concat) with flag generation, parametrised by WIDTH and IMM_BITS.
- alu_seq owns the FSM, operand latches, iteration counter, multiplier accumulator and output register.

## Test plan
All scenarios use WIDTH=16.
- Add 0xFFFF + 0x0001 accepted in cycle N → in cycle N+1: result 0x0000, carry=1, zero=1, overflow=0.
- Sub 0x0003 − 0x0005 → result 0xFFFE, carry=1, negative=1. Sub 0x8000 − 0x0001 → result 0x7FFF, overflow=1.
- Shl x=0x0001, y=3 → busy for 4 SHIFT cycles, then result 0x0010 at N+5. Shr x=0x8001, y=15 → result 0x0000, carry=0 at N+1.
- Concat x=0x0003, y=0xFFFF → result 0x07FF. Mul 0x0100 × 0x0100 → result 0x0000, carry=1 at N+17 with ALU_MUL_EN; without ALU_MUL_EN → result 0x0200 at N+1.
- Back-pressure: hold out_ready low 3 cycles → result stable and in_ready low. Then raise out_ready together with in_valid (add 1+1) → accepted the same cycle, and 0x0002 is valid on the next cycle.
- Reset asserted mid-mul → next cycle: IDLE, out_valid=0, result 0. A fresh add completes normally afterwards.
